// File: rtl/comb_sweep_pkg.sv
// Shared types and limits for the exhaustive combinational sweep checker.
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_IN_MIN  = 1;
    localparam int N_IN_MAX  = 8;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 255;

    // Width able to hold 0..dwell.
    function automatic int dwell_cnt_width(input int dwell);
        int w;
        w = $clog2(dwell + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/comb_sweep_timer.sv
// Dwell counter: counts while enabled, wraps on its terminal count and strobes tc there.
module comb_sweep_timer #(
    parameter int DWELL = 10,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TC_VAL = W'(DWELL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/comb_sweep_checker.sv
// Exhaustive sweep of an N_IN-input combinational block with truth-table capture and compare.
// Optional: define COMB_SWEEP_STOP_ON_FAIL_EN to end the sweep on the first mismatching sample.
module comb_sweep_checker
    import comb_sweep_pkg::*;
#(
    parameter int                  N_IN   = 4,
    parameter int                  DWELL  = 10,
    parameter logic [2**N_IN-1:0]  EXP_TT = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 y_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   tt_out,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      fail_vec
);

    localparam int CW = dwell_cnt_width(DWELL);
    localparam int NV = 2**N_IN;

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_bad_param
        $error("comb_sweep_checker: N_IN or DWELL out of range");
    end

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [NV-1:0]   tt_q, tt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_q, fail_d;

    logic timer_clr;
    logic timer_en;
    logic tc;
    logic mismatch;

    comb_sweep_timer #(
        .DWELL (DWELL),
        .W     (CW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (tc)
    );

    assign mismatch = (y_in != EXP_TT[vec_q]);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        tt_d      = tt_q;
        err_d     = err_q;
        fail_d    = fail_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    vec_d     = '0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    tt_d      = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    timer_clr = 1'b1;
                end
            end
            RUN: begin
                timer_en = 1'b1;
                if (tc) begin
                    tt_d[vec_q] = y_in;
                    vec_d       = vec_q + 1'b1;
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) begin
                            fail_d = vec_q;
                        end
                    end
                    // pass compares the table including the sample taken on this edge
                    if (vec_q == '1) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
                        pass_d  = (tt_d == EXP_TT);
                    end
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
                        pass_d  = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign vec_out  = vec_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign tt_out   = tt_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Bench for comb_sweep_checker: fixed-DUT vector table, hand sequences and randomized sweeps.
module tb_comb_sweep_checker;

    localparam logic [7:0] RND_EXP = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic [4:0] start_v;
    logic [7:0] rnd_fn;

    // AND, AND with wrong expectation, XOR, OR (N_IN=2), random function (N_IN=3)
    logic [3:0] vec_a, vec_b, vec_x;
    logic [1:0] vec_o;
    logic [2:0] vec_r;
    logic [15:0] tt_a, tt_b, tt_x;
    logic [3:0]  tt_o;
    logic [7:0]  tt_r;
    logic [4:0] err_a, err_b, err_x;
    logic [2:0] err_o;
    logic [3:0] err_r;
    logic [3:0] fail_a, fail_b, fail_x;
    logic [1:0] fail_o;
    logic [2:0] fail_r;
    logic [4:0] busy_v, done_v, pass_v;

    int unsigned n_vec;
    int unsigned n_err;
    int          sel;

    logic [31:0] m_vec, m_tt, m_err, m_fail;
    logic        m_busy, m_done, m_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    comb_sweep_checker #(.N_IN(4), .DWELL(10), .EXP_TT(16'h8000)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y_in(&vec_a), .vec_out(vec_a),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .tt_out(tt_a),
        .err_cnt(err_a), .fail_vec(fail_a));

    comb_sweep_checker #(.N_IN(4), .DWELL(10), .EXP_TT(16'h8001)) u_andb (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y_in(&vec_b), .vec_out(vec_b),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .tt_out(tt_b),
        .err_cnt(err_b), .fail_vec(fail_b));

    comb_sweep_checker #(.N_IN(4), .DWELL(1), .EXP_TT(16'h6996)) u_xor (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .y_in(^vec_x), .vec_out(vec_x),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .tt_out(tt_x),
        .err_cnt(err_x), .fail_vec(fail_x));

    comb_sweep_checker #(.N_IN(2), .DWELL(3), .EXP_TT(4'hE)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .y_in(|vec_o), .vec_out(vec_o),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .tt_out(tt_o),
        .err_cnt(err_o), .fail_vec(fail_o));

    comb_sweep_checker #(.N_IN(3), .DWELL(2), .EXP_TT(RND_EXP)) u_rnd (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .y_in(rnd_fn[vec_r]), .vec_out(vec_r),
        .busy(busy_v[4]), .done(done_v[4]), .pass(pass_v[4]), .tt_out(tt_r),
        .err_cnt(err_r), .fail_vec(fail_r));

    always_comb begin
        m_vec  = '0;
        m_tt   = '0;
        m_err  = '0;
        m_fail = '0;
        case (sel)
            0: begin m_vec = 32'(vec_a); m_tt = 32'(tt_a); m_err = 32'(err_a); m_fail = 32'(fail_a); end
            1: begin m_vec = 32'(vec_b); m_tt = 32'(tt_b); m_err = 32'(err_b); m_fail = 32'(fail_b); end
            2: begin m_vec = 32'(vec_x); m_tt = 32'(tt_x); m_err = 32'(err_x); m_fail = 32'(fail_x); end
            3: begin m_vec = 32'(vec_o); m_tt = 32'(tt_o); m_err = 32'(err_o); m_fail = 32'(fail_o); end
            default: begin m_vec = 32'(vec_r); m_tt = 32'(tt_r); m_err = 32'(err_r); m_fail = 32'(fail_r); end
        endcase
        m_busy = busy_v[sel];
        m_done = done_v[sel];
        m_pass = pass_v[sel];
    end

    typedef struct {
        int          sel;
        int          dwell;
        int          lat;
        logic [31:0] tt;
        int          err;
        int          fail;
        int          pass;
    } rec_t;

    rec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", name, sel, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a sweep on instance s and follow it cycle by cycle up to the done pulse.
    task automatic run_sweep(input int s, input int dwell, input int lat, input logic [31:0] e_tt,
                             input int e_err, input int e_fail, input int e_pass, input bit hold);
        sel = s;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_v[s] = 1'b0;
        chk("start_clears_pass", 32'(m_pass), 0);
        chk("start_clears_tt", m_tt, 0);
        chk("start_clears_err", m_err, 0);
        for (int k = 0; k <= lat; k++) begin
            if (k < lat) begin
                chk("busy_run", 32'(m_busy), 1);
                chk("done_early", 32'(m_done), 0);
                chk("vec_seq", m_vec, 32'(k / dwell));
                @(posedge clk);
                #1;
            end else begin
                chk("done_pulse", 32'(m_done), 1);
                chk("busy_end", 32'(m_busy), 0);
                chk("vec_wrap", m_vec, 0);
            end
        end
        start_v[s] = 1'b0;
        chk("tt_out", m_tt, e_tt);
        chk("err_cnt", m_err, 32'(e_err));
        chk("fail_vec", m_fail, 32'(e_fail));
        chk("pass", 32'(m_pass), 32'(e_pass));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(m_done), 0);
        chk("pass_held", 32'(m_pass), 32'(e_pass));
        chk("tt_held", m_tt, e_tt);
    endtask

    // Reference for the random-function instance, derived from the truth tables directly.
    task automatic rnd_model(input logic [7:0] fn, output int lat, output logic [31:0] e_tt,
                             output int e_err, output int e_fail, output int e_pass);
        logic [7:0] diff;
        int first;
        diff  = fn ^ RND_EXP;
        first = -1;
        e_err = 0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) first = i;
        end
        for (int i = 0; i < 8; i++) e_err += int'(diff[i]);
        e_pass = (diff == 0) ? 1 : 0;
        e_fail = (first < 0) ? 0 : first;
        lat    = 8 * 2;
        e_tt   = 32'(fn);
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
        if (first >= 0) begin
            lat   = (first + 1) * 2;
            e_tt  = 32'(fn) & ((32'd1 << (first + 1)) - 1);
            e_err = 1;
        end
`endif
    endtask

    initial begin
        int lat, e_err, e_fail, e_pass;
        logic [31:0] e_tt;

        n_vec   = 0;
        n_err   = 0;
        sel     = 0;
        start_v = '0;
        rnd_fn  = '0;
        rst_n   = 1'b0;

        tbl[0] = '{sel: 0, dwell: 10, lat: 160, tt: 32'h8000, err: 0, fail: 0, pass: 1};
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{sel: 1, dwell: 10, lat: 10,  tt: 32'h0000, err: 1, fail: 0, pass: 0};
`else
        tbl[1] = '{sel: 1, dwell: 10, lat: 160, tt: 32'h8000, err: 1, fail: 0, pass: 0};
`endif
        tbl[2] = '{sel: 2, dwell: 1,  lat: 16,  tt: 32'h6996, err: 0, fail: 0, pass: 1};
        tbl[3] = '{sel: 3, dwell: 3,  lat: 12,  tt: 32'h000E, err: 0, fail: 0, pass: 1};

        #1;
        chk("rst_vec", m_vec, 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_done", 32'(m_done), 0);
        chk("rst_pass", 32'(m_pass), 0);
        chk("rst_tt", m_tt, 0);
        chk("rst_err", m_err, 0);
        chk("rst_fail", m_fail, 0);
        do_reset();

        for (int i = 0; i < 4; i++) begin
            run_sweep(tbl[i].sel, tbl[i].dwell, tbl[i].lat, tbl[i].tt,
                      tbl[i].err, tbl[i].fail, tbl[i].pass, 1'b0);
            do_reset();
        end

        // start held through a whole sweep, then a single pulse from DONE
        run_sweep(0, 10, 160, 32'h8000, 0, 0, 1, 1'b1);
        run_sweep(0, 10, 160, 32'h8000, 0, 0, 1, 1'b0);

        // asynchronous reset part-way through a sweep
        sel = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (75) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vec", m_vec, 0);
        chk("midrst_busy", 32'(m_busy), 0);
        chk("midrst_done", 32'(m_done), 0);
        chk("midrst_pass", 32'(m_pass), 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", 32'(m_done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 10, 160, 32'h8000, 0, 0, 1, 1'b0);

        // randomized functions against the table-level model
        for (int t = 0; t < 24; t++) begin
            rnd_fn = (t == 5) ? RND_EXP : 8'($urandom_range(0, 255));
            rnd_model(rnd_fn, lat, e_tt, e_err, e_fail, e_pass);
            run_sweep(4, 2, lat, e_tt, e_err, e_fail, e_pass, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/comb_sweep_checker.md
Name: comb_sweep_checker

Overview:
- Self-checking exhaustive stimulus engine for N-input single-output combinational blocks (comb_Y1/comb_Y2 class).
- Drives every input vector 0..2^N_IN-1 in ascending order, holds each for DWELL cycles and samples the block output at the end of each hold.
- Captures the full truth table and compares it against an expected table.
- Replaces the hand-written #10 increment sequence with a synthesizable, parametrised sequencer that can be used on-board.

Parameters:
- N_IN, 4, number of inputs of the block under check; vec_out[N_IN-1] is the MSB (the "A" input in ABCD order); legal range 1..8.
- DWELL, 10, clock cycles each vector is held; legal range 1..255.
- EXP_TT, {2**N_IN{1'b0}}, expected truth table; bit v is the expected output for input vector v.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- y_in  in  1  output of the block under check (combinational from vec_out).
- vec_out  out  N_IN  current input vector driven to the block.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes or aborts.
- pass  out  1  high when the captured table equals EXP_TT; valid from done until the next accepted start.
- tt_out  out  2**N_IN  captured truth table; bit v = y_in sampled for vector v.
- err_cnt  out  N_IN+1  number of mismatching vectors in the last sweep.
- fail_vec  out  N_IN  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE. vec_out, busy, done, pass, tt_out, err_cnt and fail_vec all 0. Dwell counter = 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: start=1 at a clock edge (edge S).
  - On that edge: vec_out=0, busy=1, tt_out=0, err_cnt=0, fail_vec=0, pass=0, dwell counter=0.
- RUN, dwell counter: increments each edge.
- RUN, on the edge where counter==DWELL-1:
  - tt_out[vec_out] <= y_in.
  - If y_in != EXP_TT[vec_out]: err_cnt increments; fail_vec is latched only on the first mismatch.
  - Counter clears and vec_out increments.
- Vector v is therefore visible for exactly DWELL cycles, after edge S+v*DWELL.
- RUN -> DONE: on the sampling edge of vector 2**N_IN-1 (edge S+2**N_IN*DWELL).
  - busy=0, done=1 for one cycle.
  - vec_out wraps to 0.
  - pass = (final table == EXP_TT), computed including the last sample.
- DONE: tt_out, err_cnt, fail_vec and pass are held. done returns to 0 after one cycle.
  - start=1 re-enters RUN with the same actions as from IDLE.
- start while busy=1 is ignored; the sweep is not restarted.
- Reset mid-sweep: immediate return to IDLE with all reset values; no done pulse.
- Counter width: clog2(DWELL+1). err_cnt cannot overflow because its maximum value is 2**N_IN.

Optional Feature:
- Macro: COMB_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatching sample ends the sweep on that same edge.
  - State -> DONE, done=1, pass=0, err_cnt=1, fail_vec = that vector.
  - tt_out bits for unsampled vectors stay 0.
- Undefined: the sweep always covers all 2**N_IN vectors; err_cnt counts all mismatches.

Decomposition:
- Package comb_sweep_pkg:
  - state enum {IDLE, RUN, DONE};
  - clog2-based width helper for the dwell counter;
  - N_IN range limits.
- Sub-module comb_sweep_timer: dwell counter with clear and a terminal-count strobe (cnt==DWELL-1). It is instantiated once.
- Main block: FSM, vector counter, capture and compare logic.

Test Plan:
- 4-input AND DUT, N_IN=4, DWELL=10, EXP_TT=16'h8000, start at edge S -> done after exactly 160 cycles; pass=1, tt_out=16'h8000, err_cnt=0, fail_vec=0.
- Same DUT with EXP_TT=16'h8001 -> pass=0, err_cnt=1, fail_vec=0; with STOP_ON_FAIL_EN: done after 10 cycles, tt_out=16'h0000.
- 4-input XOR DUT, EXP_TT=16'h6996, DWELL=1 -> vec_out steps every cycle; done 16 cycles after start; pass=1.
- start held high for the whole sweep, then pulsed in DONE -> the single sweep is not restarted; the pulse in DONE clears pass/tt_out and starts a new 160-cycle sweep.
- rst_n driven low at cycle 75 of a sweep -> all outputs 0 asynchronously; no done pulse; the next start sweeps from vector 0.
- N_IN=2, DWELL=3, OR DUT, EXP_TT=4'hE -> vec_out sequence 0,1,2,3, each held 3 cycles; done after 12 cycles; pass=1.
